// File: rtl/filter_capture_buffer.sv
// rtl/filter_capture_buffer.sv - capture a block of filter output samples into RAM and replay it on a valid/ready stream
//
// Purpose:
//   Records DEPTH consecutive samples of a free-running filter output into an
//   internal RAM after a start request, then replays the block in order on a
//   valid/ready output stream with tlast marking the final sample. Samples are
//   stored and returned bit-exact.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   arst_n     in   asynchronous active-low reset, synchronous release
//   start      in   arm request, honoured only while idle
//   s_tdata    in   filter output sample, valid every cycle
//   m_tdata    out  replayed sample
//   m_tvalid   out  m_tdata valid
//   m_tready   in   downstream accepts the current sample
//   m_tlast    out  current sample is the last of the block
//   busy       out  capture / prefetch / drain in progress
//   done       out  one-cycle pulse after the final transfer
//   start_err  out  one-cycle pulse after a start request seen while busy

module filter_capture_buffer #(
  parameter int DATA_WIDTH = 14,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    PREFETCH,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_next;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // m_tvalid is only ever high in DRAIN, so a handshake implies DRAIN.
  assign xfer    = m_tvalid & m_tready;
  assign rd_next = rd_ptr + 1'b1;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (wr_ptr == LAST) begin
          state_nxt = PREFETCH;
        end
      end
      PREFETCH: begin
        state_nxt = DRAIN;
      end
      DRAIN: begin
        if (xfer && m_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write and read pointers. Both wrap naturally; the wrap of rd_ptr after
  // the final transfer is never used because the block returns to IDLE.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wr_ptr <= '0;
          end
        end
        CAPTURE: begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        PREFETCH: begin
          rd_ptr <= '0;
        end
        DRAIN: begin
          if (xfer) begin
            rd_ptr <= rd_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sample RAM, intentionally not reset.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  // Registered outputs. The output register is loaded one sample ahead:
  // mem[0] during PREFETCH, then mem[rd_ptr+1] on every handshake, so
  // back-to-back transfers sustain one sample per cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      m_tvalid  <= (state_nxt == DRAIN);
      done      <= xfer && m_tlast;
      start_err <= start && (state != IDLE);
      if (state == PREFETCH) begin
        m_tdata <= mem[0];
        m_tlast <= 1'b0;
      end else if (xfer) begin
        m_tdata <= mem[rd_next];
        m_tlast <= (rd_next == LAST);
      end
    end
  end

endmodule

// File: tb/tb_filter_capture_buffer.sv
// tb/tb_filter_capture_buffer.sv - directed bench for filter_capture_buffer (DEPTH=128 and DEPTH=2 instances)

module tb_filter_capture_buffer;

  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic arst_n = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  // DEPTH=128 instance
  logic        a_start = 1'b0;
  logic [13:0] a_sd = '0;
  logic [13:0] a_data;
  logic        a_valid;
  logic        a_ready = 1'b0;
  logic        a_last;
  logic        a_busy;
  logic        a_done;
  logic        a_err;

  // DEPTH=2 instance
  logic        b_start = 1'b0;
  logic [13:0] b_sd = '0;
  logic [13:0] b_data;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic        b_last;
  logic        b_busy;
  logic        b_done;
  logic        b_err;

  filter_capture_buffer #(.DATA_WIDTH(14), .DEPTH(128)) dut_a (
    .clk(clk), .arst_n(arst_n), .start(a_start), .s_tdata(a_sd),
    .m_tdata(a_data), .m_tvalid(a_valid), .m_tready(a_ready), .m_tlast(a_last),
    .busy(a_busy), .done(a_done), .start_err(a_err)
  );

  filter_capture_buffer #(.DATA_WIDTH(14), .DEPTH(2)) dut_b (
    .clk(clk), .arst_n(arst_n), .start(b_start), .s_tdata(b_sd),
    .m_tdata(b_data), .m_tvalid(b_valid), .m_tready(b_ready), .m_tlast(b_last),
    .busy(b_busy), .done(b_done), .start_err(b_err)
  );

  // Gated clock so the async reset can be applied with the clock stopped.
  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Table record for the DEPTH=2 instance: inputs for the cycle, and the
  // outputs expected during that cycle. flg = {valid, last, busy, done, start_err}.
  typedef struct packed {
    logic        st;
    logic        rdy;
    logic [13:0] sd;
    logic [4:0]  flg;
    logic [13:0] dat;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rdy, input logic [13:0] sd,
                              input logic [4:0] flg, input logic [13:0] dat);
    return vec_t'({st, rdy, sd, flg, dat});
  endfunction

  typedef logic [13:0] blk_t [128];

  blk_t ramp, sgn, mix, neg;
  vec_t vt [16];

  task automatic capture(input blk_t p, input int err_k, input bit already);
    if (!already) begin
      @(negedge clk);
      chk("cap_idle", {a_busy, a_valid}, 2'b00);
      a_start = 1'b1;
    end
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      if (k == 0) chk("cap_first", {a_busy, a_done, a_valid}, 3'b100);
      if (err_k >= 0 && k == err_k + 1) chk("cap_start_err", a_err, 1'b1);
      a_start = (k == err_k);
      a_sd = p[k];
    end
  endtask

  task automatic drain(input blk_t p, input bit rnd, input int err_idx, input int stop_at, input bit b2b);
    int idx;
    int cyc;
    bit held;
    bit errp;
    bit errsent;
    logic [13:0] hd;
    logic hl;
    idx = 0; cyc = 0; held = 0; errp = 0; errsent = 0; hd = '0; hl = 1'b0;
    while (idx < 128 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      a_start = 1'b0;
      if (cyc == 1) chk("prefetch_state", {a_valid, a_busy}, 2'b01);
      if (held) chk("hold_stable", {a_valid, a_last, a_data}, {1'b1, hl, hd});
      if (errp) begin
        chk("drain_start_err", a_err, 1'b1);
        errp = 0;
      end
      if (idx == stop_at) begin
        chk("stop_valid", a_valid, 1'b1);
        return;
      end
      a_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (a_valid && idx == err_idx && !errsent) begin
        a_start = 1'b1;
        errp = 1;
        errsent = 1;
      end
      if (a_valid && a_ready) begin
        chk($sformatf("beat%0d", idx), {a_data, a_last}, {p[idx], (idx == 127)});
        idx++;
      end
      held = a_valid && !a_ready;
      hd = a_data;
      hl = a_last;
    end
    if (idx < 128) chk("drain_timeout", idx, 128);
    if (!rnd) chk("full_rate_cycles", cyc, 129);
    @(negedge clk);
    chk("done_pulse", {a_done, a_busy, a_valid}, 3'b100);
    a_ready = 1'b0;
    if (b2b) begin
      a_start = 1'b1;
    end else begin
      @(negedge clk);
      chk("done_end", {a_done, a_busy, a_valid}, 3'b000);
    end
  endtask

  initial begin
    logic [13:0] sp [4];
    logic [31:0] act;
    logic [31:0] exp;
    sp = '{14'h3FC0, 14'h0040, 14'h2000, 14'h1FFF};
    for (int k = 0; k < 128; k++) begin
      ramp[k] = 14'(k);
      sgn[k]  = sp[k % 4];
      mix[k]  = 14'(k * 37 + 11);
      neg[k]  = ~14'(k);
    end

    //            st rdy sd        v l b d e    dat
    vt[0]  = mk(1, 0, 14'h0000, 5'b00000, 14'h0000);
    vt[1]  = mk(0, 0, 14'h0005, 5'b00100, 14'h0000);
    vt[2]  = mk(0, 0, 14'h3FFD, 5'b00100, 14'h0000);
    vt[3]  = mk(0, 0, 14'h0009, 5'b00100, 14'h0000);
    vt[4]  = mk(0, 1, 14'h0000, 5'b10100, 14'h0005);
    vt[5]  = mk(0, 0, 14'h0000, 5'b11100, 14'h3FFD);
    vt[6]  = mk(1, 0, 14'h0000, 5'b11100, 14'h3FFD);
    vt[7]  = mk(0, 1, 14'h0000, 5'b11101, 14'h3FFD);
    vt[8]  = mk(1, 0, 14'h0000, 5'b00010, 14'h0000);
    vt[9]  = mk(0, 0, 14'h2000, 5'b00100, 14'h0000);
    vt[10] = mk(0, 0, 14'h1FFF, 5'b00100, 14'h0000);
    vt[11] = mk(0, 0, 14'h0000, 5'b00100, 14'h0000);
    vt[12] = mk(0, 1, 14'h0000, 5'b10100, 14'h2000);
    vt[13] = mk(1, 1, 14'h0000, 5'b11100, 14'h1FFF);
    vt[14] = mk(0, 1, 14'h0000, 5'b00011, 14'h0000);
    vt[15] = mk(0, 0, 14'h0000, 5'b00000, 14'h0000);

    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {a_data, a_valid, a_last, a_busy, a_done, a_err}, 32'h0);

    // DEPTH=2: ramp, backpressure, start while busy, back-to-back, sign extremes
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      act = {b_valid, b_last, b_busy, b_done, b_err, (vt[i].flg[4] ? b_data : 14'h0)};
      exp = {vt[i].flg, vt[i].dat};
      chk($sformatf("d2_vec%0d", i), act, exp);
      b_start = vt[i].st;
      b_ready = vt[i].rdy;
      b_sd    = vt[i].sd;
    end

    // ramp at full rate
    capture(ramp, -1, 0);
    drain(ramp, 0, -1, -1, 0);

    // ramp under random backpressure
    capture(ramp, -1, 0);
    drain(ramp, 1, -1, -1, 0);

    // signed fixed-point extremes
    capture(sgn, -1, 0);
    drain(sgn, 0, -1, -1, 0);

    // start while busy in CAPTURE cycle 5 and in DRAIN
    capture(mix, 5, 0);
    drain(mix, 1, 60, -1, 0);

    // back-to-back blocks, second start in the done cycle
    capture(ramp, -1, 0);
    drain(ramp, 0, -1, -1, 1);
    capture(neg, -1, 1);
    drain(neg, 0, -1, -1, 0);

    // async reset mid-drain with clock stopped
    capture(mix, -1, 0);
    drain(mix, 0, -1, 40, 0);
    clk_run = 1'b0;
    #2 arst_n = 1'b0;
    #1 chk("async_rst_outputs", {a_valid, a_busy, a_last}, 3'b000);
    #4 arst_n = 1'b1;
    #2 clk_run = 1'b1;
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", i), {a_valid, a_busy, a_done}, 3'b000);
    end
    a_ready = 1'b0;
    capture(ramp, -1, 0);
    drain(ramp, 0, -1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
